chess_turn_scheduler: RTL and testbench

Game-sequencing controller for the chess clock. It sits between the player push-buttons, the set/count control logic and the countdown datapath. It debounces the two player buttons and decides which player's clock decrements. It also handles pause/resume and flag-fall (time exhausted), and freezes the game until the next set phase.

---
 rtl/chess_turn_scheduler.sv | 213 +++++++++++++++++++++
 tb/tb_chess_turn_scheduler.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/chess_turn_scheduler.sv
// Chess clock turn scheduler: debounces both player buttons and sequences turns, pause and flag-fall.
// Optional Fischer increment pulses are built only when FISCHER_INC_EN is defined.
module chess_turn_scheduler #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int CNT_W           = 20
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       set_mode,
    input  logic       pause_req,
    input  logic       btn1,
    input  logic       btn2,
    input  logic       zero1,
    input  logic       zero2,
    output logic       run1,
    output logic       run2,
    output logic [1:0] player,
    output logic [1:0] flag,
    output logic       game_over,
    output logic [7:0] moves,
    output logic       inc1,
    output logic       inc2
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SETUP  = 3'd1,
        S_READY  = 3'd2,
        S_RUN_P1 = 3'd3,
        S_RUN_P2 = 3'd4,
        S_PAUSE  = 3'd5,
        S_FLAG   = 3'd6
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [1:0]       btn_raw_s;
    logic [1:0]       sync1_r, sync2_r, stable_r, press_r;
    logic [CNT_W-1:0] cnt_r [2];
    logic             ev1_s, ev2_s;

    state_t     state_r, state_next_s;
    logic       paused_r, paused_next_s;   // 0: P1 was running, 1: P2 was running
    logic [1:0] flag_r, flag_next_s;
    logic [7:0] moves_r, moves_next_s, moves_inc_s;
    logic       run1_s, run2_s, game_over_s;
    logic [1:0] player_s;
    logic       run1_r, run2_r, game_over_r;
    logic [1:0] player_r;

    assign btn_raw_s   = {btn2, btn1};
    assign ev1_s       = press_r[0];
    assign ev2_s       = press_r[1];
    assign moves_inc_s = (moves_r == 8'd255) ? moves_r : (moves_r + 8'd1);

    // Button synchronizers, stability counters and one-cycle press events
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_r  <= 2'b00;
            sync2_r  <= 2'b00;
            stable_r <= 2'b00;
            press_r  <= 2'b00;
            for (int i = 0; i < 2; i++) begin
                cnt_r[i] <= {CNT_W{1'b0}};
            end
        end else begin
            sync1_r <= btn_raw_s;
            sync2_r <= sync1_r;
            for (int i = 0; i < 2; i++) begin
                press_r[i] <= 1'b0;
                if (sync2_r[i] == stable_r[i]) begin
                    cnt_r[i] <= {CNT_W{1'b0}};
                end else if (cnt_r[i] == CNT_LAST) begin
                    cnt_r[i]    <= {CNT_W{1'b0}};
                    stable_r[i] <= sync2_r[i];
                    press_r[i]  <= sync2_r[i];
                end else begin
                    cnt_r[i] <= cnt_r[i] + CNT_W'(1);
                end
            end
        end
    end

    // State, game bookkeeping and Moore output registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r     <= S_IDLE;
            paused_r    <= 1'b0;
            flag_r      <= 2'b00;
            moves_r     <= 8'd0;
            run1_r      <= 1'b0;
            run2_r      <= 1'b0;
            player_r    <= 2'b00;
            game_over_r <= 1'b0;
        end else begin
            state_r     <= state_next_s;
            paused_r    <= paused_next_s;
            flag_r      <= flag_next_s;
            moves_r     <= moves_next_s;
            run1_r      <= run1_s;
            run2_r      <= run2_s;
            player_r    <= player_s;
            game_over_r <= game_over_s;
        end
    end

    // Next-state logic; set_mode overrides everything
    always_comb begin
        state_next_s  = state_r;
        paused_next_s = paused_r;
        flag_next_s   = flag_r;
        moves_next_s  = moves_r;
        if (set_mode) begin
            state_next_s = S_SETUP;
            flag_next_s  = 2'b00;
            moves_next_s = 8'd0;
        end else begin
            case (state_r)
                S_IDLE:  state_next_s = S_READY;
                S_SETUP: state_next_s = S_READY;
                S_READY: begin
                    if (ev1_s && !ev2_s) begin
                        state_next_s = S_RUN_P2;
                    end else if (ev2_s && !ev1_s) begin
                        state_next_s = S_RUN_P1;
                    end else begin
                        state_next_s = S_READY;
                    end
                end
                S_RUN_P1: begin
                    if (zero1) begin
                        state_next_s = S_FLAG;
                        flag_next_s  = 2'b01;
                    end else if (pause_req) begin
                        state_next_s  = S_PAUSE;
                        paused_next_s = 1'b0;
                    end else if (ev1_s) begin
                        state_next_s = S_RUN_P2;
                        moves_next_s = moves_inc_s;
                    end else begin
                        state_next_s = S_RUN_P1;
                    end
                end
                S_RUN_P2: begin
                    if (zero2) begin
                        state_next_s = S_FLAG;
                        flag_next_s  = 2'b10;
                    end else if (pause_req) begin
                        state_next_s  = S_PAUSE;
                        paused_next_s = 1'b1;
                    end else if (ev2_s) begin
                        state_next_s = S_RUN_P1;
                        moves_next_s = moves_inc_s;
                    end else begin
                        state_next_s = S_RUN_P2;
                    end
                end
                S_PAUSE: begin
                    if (pause_req) begin
                        state_next_s = paused_r ? S_RUN_P2 : S_RUN_P1;
                    end else begin
                        state_next_s = S_PAUSE;
                    end
                end
                S_FLAG:  state_next_s = S_FLAG;
                default: state_next_s = S_IDLE;
            endcase
        end
    end

    // Output decode from the upcoming state so outputs move on the same edge as the state
    always_comb begin
        run1_s      = (state_next_s == S_RUN_P1);
        run2_s      = (state_next_s == S_RUN_P2);
        game_over_s = (state_next_s == S_FLAG);
        if ((state_next_s == S_RUN_P1) || ((state_next_s == S_PAUSE) && !paused_next_s)) begin
            player_s = 2'b01;
        end else if ((state_next_s == S_RUN_P2) || ((state_next_s == S_PAUSE) && paused_next_s)) begin
            player_s = 2'b10;
        end else begin
            player_s = 2'b00;
        end
    end

`ifdef FISCHER_INC_EN
    logic inc1_r, inc2_r;

    // Increment pulse credited to the player who just ended a running turn
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            inc1_r <= 1'b0;
            inc2_r <= 1'b0;
        end else begin
            inc1_r <= (state_r == S_RUN_P1) && (state_next_s == S_RUN_P2);
            inc2_r <= (state_r == S_RUN_P2) && (state_next_s == S_RUN_P1);
        end
    end

    assign inc1 = inc1_r;
    assign inc2 = inc2_r;
`else
    assign inc1 = 1'b0;
    assign inc2 = 1'b0;
`endif

    assign run1      = run1_r;
    assign run2      = run2_r;
    assign player    = player_r;
    assign flag      = flag_r;
    assign game_over = game_over_r;
    assign moves     = moves_r;

endmodule

// File: tb/tb_chess_turn_scheduler.sv
// Scoreboard bench for chess_turn_scheduler: expected output snapshots are queued by the
// stimulus and popped by a monitor whenever the DUT output vector changes.
module tb_chess_turn_scheduler;

    logic       clk = 1'b0;
    logic       reset, set_mode, pause_req, btn1, btn2, zero1, zero2;
    logic       run1, run2, game_over, inc1, inc2;
    logic [1:0] player, flag;
    logic [7:0] moves;

`ifdef FISCHER_INC_EN
    localparam bit FISCHER = 1'b1;
`else
    localparam bit FISCHER = 1'b0;
`endif

    int tests = 0;
    int fails = 0;
    logic [17:0] exp_q[$];
    logic [17:0] cur;

    chess_turn_scheduler #(.DEBOUNCE_CYCLES(4), .CNT_W(3)) dut (
        .clk(clk), .reset(reset), .set_mode(set_mode), .pause_req(pause_req),
        .btn1(btn1), .btn2(btn2), .zero1(zero1), .zero2(zero2),
        .run1(run1), .run2(run2), .player(player), .flag(flag),
        .game_over(game_over), .moves(moves), .inc1(inc1), .inc2(inc2)
    );

    always #5 clk = ~clk;

    assign cur = {run1, run2, player, flag, game_over, moves, inc1, inc2};

    function automatic logic [17:0] snap(input logic r1, input logic r2, input logic [1:0] pl,
                                         input logic [1:0] fl, input logic go, input logic [7:0] mv);
        return {r1, r2, pl, fl, go, mv, 2'b00};
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] expv);
        tests++;
        if (got !== expv) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, got, expv);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic press(input int b);
        if (b == 1) btn1 = 1'b1;
        else        btn2 = 1'b1;
        tick(7);
        btn1 = 1'b0;
        btn2 = 1'b0;
        tick(8);
    endtask

    task automatic pulse_pause();
        pause_req = 1'b1;
        tick(1);
        pause_req = 1'b0;
        tick(2);
    endtask

    // Turn switch: with increments the pulse snapshot precedes the settled one
    task automatic push_sw(input logic [17:0] s, input int which);
        logic [17:0] pulsed;
        pulsed = (which == 1) ? (s | 18'd2) : (s | 18'd1);
        if (FISCHER) exp_q.push_back(pulsed);
        exp_q.push_back(s);
    endtask

    // Monitor: every change of the output vector must match the next queued snapshot
    initial begin
        logic [17:0] prev;
        logic [17:0] e;
        prev = 18'd0;
        forever begin
            @(negedge clk);
            if (cur !== prev) begin
                tests++;
                if (exp_q.size() == 0) begin
                    fails++;
                    $display("FAIL out_unexpected: got %h expected no change from %h", cur, prev);
                end else begin
                    e = exp_q.pop_front();
                    if (cur !== e) begin
                        fails++;
                        $display("FAIL out_seq: got %h expected %h", cur, e);
                    end
                end
                tests++;
                if (run1 && run2) begin
                    fails++;
                    $display("FAIL run_exclusive: got run1=%b run2=%b expected not both 1", run1, run2);
                end
                prev = cur;
            end
        end
    end

    initial begin
        int k;
        logic [7:0] m;
        reset = 1'b1; set_mode = 1'b0; pause_req = 1'b0;
        btn1 = 1'b0; btn2 = 1'b0; zero1 = 1'b0; zero2 = 1'b0;
        #1 reset = 1'b0;
        tick(3);
        chk("reset_outputs", {14'd0, cur}, 32'd0);
        reset = 1'b1;
        set_mode = 1'b1;
        tick(2);
        set_mode = 1'b0;
        tick(2);

        // First press from READY hands the clock to P2 without counting a move
        exp_q.push_back(snap(1'b0, 1'b1, 2'b10, 2'b00, 1'b0, 8'd0));
        btn1 = 1'b1;
        k = 0;
        for (int j = 1; j <= 12; j++) begin
            tick(1);
            if (run2 && (k == 0)) k = j;
        end
        chk("press_latency", {31'd0, (k >= 6) && (k <= 7)}, 32'd1);
        chk("first_press_moves", {24'd0, moves}, 32'd0);
        btn1 = 1'b0;
        tick(8);
        btn2 = 1'b1;
        tick(2);
        btn2 = 1'b0;
        tick(10);

        push_sw(snap(1'b1, 1'b0, 2'b01, 2'b00, 1'b0, 8'd1), 2);
        press(2);
        push_sw(snap(1'b0, 1'b1, 2'b10, 2'b00, 1'b0, 8'd2), 1);
        press(1);
        push_sw(snap(1'b1, 1'b0, 2'b01, 2'b00, 1'b0, 8'd3), 2);
        press(2);
        chk("moves_three", {24'd0, moves}, 32'd3);

        // Pause keeps the player indication; button presses are lost while paused
        exp_q.push_back(snap(1'b0, 1'b0, 2'b01, 2'b00, 1'b0, 8'd3));
        pulse_pause();
        press(1);
        exp_q.push_back(snap(1'b1, 1'b0, 2'b01, 2'b00, 1'b0, 8'd3));
        pulse_pause();
        chk("resume_player", {30'd0, player}, 32'd1);

        // zero1 coincides with a btn1 event: flag-fall wins
        exp_q.push_back(snap(1'b0, 1'b0, 2'b00, 2'b01, 1'b1, 8'd3));
        btn1 = 1'b1;
        tick(6);
        zero1 = 1'b1;
        tick(3);
        btn1 = 1'b0;
        tick(8);
        chk("flag_p1", {30'd0, flag}, 32'd1);
        pulse_pause();
        press(2);
        zero1 = 1'b0;
        exp_q.push_back(18'd0);
        set_mode = 1'b1;
        tick(2);
        set_mode = 1'b0;
        tick(2);
        chk("setup_clears_moves", {24'd0, moves}, 32'd0);

        // Long game to reach moves saturation
        exp_q.push_back(snap(1'b1, 1'b0, 2'b01, 2'b00, 1'b0, 8'd0));
        press(2);
        for (int n = 1; n <= 256; n++) begin
            m = (n > 255) ? 8'd255 : n[7:0];
            if ((n % 2) == 1) begin
                push_sw(snap(1'b0, 1'b1, 2'b10, 2'b00, 1'b0, m), 1);
                press(1);
            end else begin
                push_sw(snap(1'b1, 1'b0, 2'b01, 2'b00, 1'b0, m), 2);
                press(2);
            end
        end
        chk("moves_saturated", {24'd0, moves}, 32'd255);

        // Asynchronous reset while P1 is running
        exp_q.push_back(18'd0);
        @(posedge clk);
        #2 reset = 1'b0;
        #1;
        chk("async_run1", {31'd0, run1}, 32'd0);
        chk("async_player", {30'd0, player}, 32'd0);
        chk("async_moves", {24'd0, moves}, 32'd0);
        chk("async_all", {14'd0, cur}, 32'd0);
        tick(2);
        reset = 1'b1;
        tick(3);
        exp_q.push_back(snap(1'b0, 1'b1, 2'b10, 2'b00, 1'b0, 8'd0));
        press(1);
        exp_q.push_back(snap(1'b0, 1'b0, 2'b00, 2'b10, 1'b1, 8'd0));
        zero2 = 1'b1;
        tick(3);
        zero2 = 1'b0;
        tick(2);
        chk("flag_p2", {30'd0, flag}, 32'd2);

        for (int j = 0; (j < 50) && (exp_q.size() != 0); j++) tick(1);
        tick(2);
        chk("scoreboard_drained", exp_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
